ctr_multi: RTL and testbench

Parametrised, single-clock reciprocal counter with a selectable number of input channels.
- A begin edge on one channel opens the measurement gate; an end edge on another channel closes it.
- While the gate is open, the block counts event edges on a third selectable channel (cnx) and clk cycles (cnr), so an upper layer can compute frequency, period or interval.
- Successor to the fixed two-input counter: adds selectable channel count, per-gate edge polarity, abort, saturation and an overflow flag.

---
 rtl/ctr_multi.sv | 111 +++++++++++
 tb/tb_ctr_multi.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctr_multi.sv
// Reciprocal counter: gates on selectable begin/end channel edges and, while the gate is open,
// counts event edges (cnx) and clk cycles (cnr), both saturating, with a sticky overflow flag.
module ctr_multi #(
    parameter int size = 24,
    parameter int sw   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2**sw-1:0]  inp,
    input  logic [sw-1:0]     bis,
    input  logic              bed,
    input  logic [sw-1:0]     eis,
    input  logic              eed,
    input  logic [sw-1:0]     xis,
    input  logic              brq,
    input  logic              erq,
    output logic              bac,
    output logic              eac,
    output logic [size-1:0]   cnx,
    output logic [size-1:0]   cnr,
    output logic              ovf
);

    localparam int nch = 2**sw;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ARMED = 3'd1;
    localparam logic [2:0] RUN   = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [nch-1:0]  s1, s2, s3;
    logic [nch-1:0]  rise, fall;
    logic            beg_pulse, end_pulse, evt_pulse;
    logic [2:0]      state, state_d;
    logic [size-1:0] cnx_d, cnr_d;
    logic            ovf_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= inp;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    assign beg_pulse = bed ? fall[bis] : rise[bis];
    assign end_pulse = eed ? fall[eis] : rise[eis];
    assign evt_pulse = rise[xis];

    always_comb begin
        state_d = state;
        cnx_d   = cnx;
        cnr_d   = cnr;
        ovf_d   = ovf;
        if (!brq) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: state_d = ARMED;
                ARMED: begin
                    if (beg_pulse) begin
                        state_d = RUN;
                        cnr_d   = {{(size-1){1'b0}}, 1'b1};
                        cnx_d   = {{(size-1){1'b0}}, evt_pulse};
                        ovf_d   = 1'b0;
                    end
                end
                RUN, STOP: begin
                    // Saturate rather than wrap; any blocked increment marks overflow.
                    if (&cnr) ovf_d = 1'b1;
                    else      cnr_d = cnr + 1'b1;
                    if (evt_pulse) begin
                        if (&cnx) ovf_d = 1'b1;
                        else      cnx_d = cnx + 1'b1;
                    end
                    if (state == RUN && erq)       state_d = STOP;
                    if (state == STOP && end_pulse) state_d = DONE;
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnx   <= '0;
            cnr   <= '0;
            ovf   <= 1'b0;
            bac   <= 1'b0;
            eac   <= 1'b0;
        end else begin
            state <= state_d;
            cnx   <= cnx_d;
            cnr   <= cnr_d;
            ovf   <= ovf_d;
            bac   <= (state_d == RUN) || (state_d == STOP) || (state_d == DONE);
            eac   <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_ctr_multi.sv
// Directed bench for ctr_multi (size=8, sw=2); edge counts are relative to the last stimulus point.
module tb_ctr_multi;

    logic       clk;
    logic       rst;
    logic [3:0] inp;
    logic [1:0] bis, eis, xis;
    logic       bed, eed, brq, erq;
    logic       bac, eac, ovf;
    logic [7:0] cnx, cnr;

    int n_chk  = 0;
    int n_fail = 0;

    ctr_multi #(.size(8), .sw(2)) dut (
        .clk(clk), .rst(rst), .inp(inp), .bis(bis), .bed(bed), .eis(eis), .eed(eed),
        .xis(xis), .brq(brq), .erq(erq), .bac(bac), .eac(eac), .cnx(cnx), .cnr(cnr),
        .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after an edge with reset released and all inputs idle.
    task automatic do_reset(input logic [3:0] inp0);
        rst = 1'b0;
        inp = inp0;
        bis = 2'd0; eis = 2'd0; xis = 2'd0;
        bed = 1'b0; eed = 1'b0; brq = 1'b0; erq = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        inp = 4'hf;
        #3;
        rst = 1'b0;
        #1;
        n_chk++; if ({bac, eac, ovf} !== 3'b000) begin n_fail++;
            $display("FAIL reset_flags: got %b want 000", {bac, eac, ovf}); end
        n_chk++; if ({cnx, cnr} !== 16'h0) begin n_fail++;
            $display("FAIL reset_counts: got cnx=%0d cnr=%0d want 0 0", cnx, cnr); end
        do_reset(4'h0);
    endtask

    task automatic test_frequency();
        do_reset(4'h0);
        brq = 1'b1;
        for (int c = 1; c <= 34; c++) begin
            step();
            if (c == 4) begin
                n_chk++; if (bac !== 1'b0) begin n_fail++;
                    $display("FAIL freq_bac_early: got %b want 0", bac); end
            end
            if (c == 5) begin
                n_chk++; if ({bac, cnr, cnx} !== {1'b1, 8'd1, 8'd1}) begin n_fail++;
                    $display("FAIL freq_open: got bac=%b cnr=%0d cnx=%0d want 1 1 1",
                             bac, cnr, cnx); end
            end
            if (c == 28) begin
                n_chk++; if (eac !== 1'b0) begin n_fail++;
                    $display("FAIL freq_eac_early: got %b want 0", eac); end
            end
            if (c == 29) begin
                n_chk++; if ({eac, bac, cnx, cnr, ovf} !== {1'b1, 1'b1, 8'd7, 8'd25, 1'b0})
                begin n_fail++;
                    $display("FAIL freq_done: got eac=%b bac=%b cnx=%0d cnr=%0d ovf=%b want 1 1 7 25 0",
                             eac, bac, cnx, cnr, ovf); end
            end
            if (c == 34) begin
                n_chk++; if ({cnx, cnr} !== {8'd7, 8'd25}) begin n_fail++;
                    $display("FAIL freq_hold: got cnx=%0d cnr=%0d want 7 25", cnx, cnr); end
            end
            inp[0] = ((c % 4) >= 2);
            if (c == 25) erq = 1'b1;
        end
    endtask

    task automatic test_routing();
        do_reset(4'b0010);
        bis = 2'd1; bed = 1'b1; eis = 2'd2; eed = 1'b0; xis = 2'd3;
        brq = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            step();
            if (c == 6) begin
                n_chk++; if (bac !== 1'b0) begin n_fail++;
                    $display("FAIL route_bac_early: got %b want 0", bac); end
            end
            if (c == 7) begin
                n_chk++; if ({bac, cnr} !== {1'b1, 8'd1}) begin n_fail++;
                    $display("FAIL route_open: got bac=%b cnr=%0d want 1 1", bac, cnr); end
            end
            if (c == 14) begin
                n_chk++; if (eac !== 1'b0) begin n_fail++;
                    $display("FAIL route_eac_early: got %b want 0", eac); end
            end
            if (c == 15) begin
                n_chk++; if ({eac, cnr, cnx} !== {1'b1, 8'd9, 8'd0}) begin n_fail++;
                    $display("FAIL route_done: got eac=%b cnr=%0d cnx=%0d want 1 9 0",
                             eac, cnr, cnx); end
            end
            if (c == 4)  inp[1] = 1'b0;
            if (c == 5)  inp[2] = 1'b1;
            if (c == 7)  inp[2] = 1'b0;
            if (c == 9)  erq = 1'b1;
            if (c == 12) inp[2] = 1'b1;
        end
    endtask

    task automatic test_overflow();
        do_reset(4'h0);
        bis = 2'd0; eis = 2'd1; xis = 2'd2;
        brq = 1'b1;
        for (int c = 1; c <= 313; c++) begin
            step();
            if (c == 259) begin
                n_chk++; if ({cnr, ovf} !== {8'd255, 1'b0}) begin n_fail++;
                    $display("FAIL ovf_at_max: got cnr=%0d ovf=%b want 255 0", cnr, ovf); end
            end
            if (c == 260) begin
                n_chk++; if ({cnr, ovf} !== {8'd255, 1'b1}) begin n_fail++;
                    $display("FAIL ovf_set: got cnr=%0d ovf=%b want 255 1", cnr, ovf); end
            end
            if (c == 303) begin
                n_chk++; if ({eac, cnr, ovf, cnx} !== {1'b1, 8'd255, 1'b1, 8'd0}) begin n_fail++;
                    $display("FAIL ovf_done: got eac=%b cnr=%0d ovf=%b cnx=%0d want 1 255 1 0",
                             eac, cnr, ovf, cnx); end
            end
            if (c == 305) begin
                n_chk++; if ({bac, eac, ovf, cnr} !== {1'b0, 1'b0, 1'b1, 8'd255}) begin n_fail++;
                    $display("FAIL ovf_abort_hold: got bac=%b eac=%b ovf=%b cnr=%0d want 0 0 1 255",
                             bac, eac, ovf, cnr); end
            end
            if (c == 312) begin
                n_chk++; if (ovf !== 1'b1) begin n_fail++;
                    $display("FAIL ovf_armed_hold: got %b want 1", ovf); end
            end
            if (c == 313) begin
                n_chk++; if ({bac, cnr, ovf} !== {1'b1, 8'd1, 1'b0}) begin n_fail++;
                    $display("FAIL ovf_clear: got bac=%b cnr=%0d ovf=%b want 1 1 0",
                             bac, cnr, ovf); end
            end
            if (c == 2)   inp[0] = 1'b1;
            if (c == 262) erq = 1'b1;
            if (c == 300) inp[1] = 1'b1;
            if (c == 304) brq = 1'b0;
            if (c == 305) begin inp = 4'h0; erq = 1'b0; end
            if (c == 306) brq = 1'b1;
            if (c == 310) inp[0] = 1'b1;
        end
    endtask

    task automatic test_abort();
        do_reset(4'h0);
        brq = 1'b1;
        for (int c = 1; c <= 23; c++) begin
            step();
            if (c == 14) begin
                n_chk++; if ({bac, cnr} !== {1'b1, 8'd10}) begin n_fail++;
                    $display("FAIL abort_run: got bac=%b cnr=%0d want 1 10", bac, cnr); end
            end
            if (c == 15) begin
                n_chk++; if ({bac, eac, cnr, cnx} !== {1'b0, 1'b0, 8'd10, 8'd1}) begin n_fail++;
                    $display("FAIL abort_idle: got bac=%b eac=%b cnr=%0d cnx=%0d want 0 0 10 1",
                             bac, eac, cnr, cnx); end
            end
            if (c == 18) begin
                n_chk++; if ({bac, cnr, cnx} !== {1'b0, 8'd10, 8'd1}) begin n_fail++;
                    $display("FAIL abort_frozen: got bac=%b cnr=%0d cnx=%0d want 0 10 1",
                             bac, cnr, cnx); end
            end
            if (c == 22) begin
                n_chk++; if (bac !== 1'b0) begin n_fail++;
                    $display("FAIL abort_armed: got bac=%b want 0", bac); end
            end
            if (c == 23) begin
                n_chk++; if ({bac, cnr, cnx} !== {1'b1, 8'd1, 8'd1}) begin n_fail++;
                    $display("FAIL abort_rearm: got bac=%b cnr=%0d cnx=%0d want 1 1 1",
                             bac, cnr, cnx); end
            end
            if (c == 2)  inp[0] = 1'b1;
            if (c == 14) brq = 1'b0;
            if (c == 15) inp[0] = 1'b0;
            if (c == 18) brq = 1'b1;
            if (c == 20) inp[0] = 1'b1;
        end
    endtask

    task automatic test_async_reset();
        do_reset(4'h0);
        eis = 2'd1;
        brq = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (c == 2) inp[0] = 1'b1;
            if (c == 6) erq = 1'b1;
        end
        n_chk++; if ({bac, cnr, cnx} !== {1'b1, 8'd6, 8'd1}) begin n_fail++;
            $display("FAIL arst_pre: got bac=%b cnr=%0d cnx=%0d want 1 6 1", bac, cnr, cnx); end
        #2;
        rst = 1'b0;
        #1;
        n_chk++; if ({bac, eac, ovf, cnx, cnr} !== 19'h0) begin n_fail++;
            $display("FAIL arst_clear: got bac=%b eac=%b ovf=%b cnx=%0d cnr=%0d want all 0",
                     bac, eac, ovf, cnx, cnr); end
        #1;
        rst = 1'b1;
        step();
        step();
        n_chk++; if ({bac, cnr} !== {1'b0, 8'd0}) begin n_fail++;
            $display("FAIL arst_armed: got bac=%b cnr=%0d want 0 0", bac, cnr); end
        step();
        n_chk++; if ({bac, cnr} !== {1'b1, 8'd1}) begin n_fail++;
            $display("FAIL arst_reopen: got bac=%b cnr=%0d want 1 1", bac, cnr); end
    endtask

    task automatic test_erq_first();
        do_reset(4'h0);
        eis = 2'd1;
        brq = 1'b1;
        erq = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            step();
            if (c == 6) begin
                n_chk++; if ({bac, eac} !== 2'b10) begin n_fail++;
                    $display("FAIL erq_run_end_ignored: got bac=%b eac=%b want 1 0", bac, eac); end
            end
            if (c == 10) begin
                n_chk++; if (eac !== 1'b0) begin n_fail++;
                    $display("FAIL erq_eac_early: got %b want 0", eac); end
            end
            if (c == 11) begin
                n_chk++; if ({eac, cnr, cnx} !== {1'b1, 8'd7, 8'd1}) begin n_fail++;
                    $display("FAIL erq_done: got eac=%b cnr=%0d cnx=%0d want 1 7 1",
                             eac, cnr, cnx); end
            end
            if (c == 2) inp[0] = 1'b1;
            if (c == 3) inp[1] = 1'b1;
            if (c == 6) inp[1] = 1'b0;
            if (c == 8) inp[1] = 1'b1;
        end
    endtask

    initial begin
        rst = 1'b1;
        inp = 4'h0;
        bis = 2'd0; eis = 2'd0; xis = 2'd0;
        bed = 1'b0; eed = 1'b0; brq = 1'b0; erq = 1'b0;
        test_reset();
        test_frequency();
        test_routing();
        test_overflow();
        test_abort();
        test_async_reset();
        test_erq_first();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
